bcp_imply_arb: RTL and testbench
================================

// Module: bcp_imply_arb
// PURPOSE
//  Collects unit-clause implications and conflicts from NUM_PE BCP engines and serialises them into the UCQ.
//  Sits between the BCP PE array and the UCQ write port; owns the per-PE halt used for implication backpressure.
//  Arbitration is round-robin. Sticky global conflict is raised until the solver clears it.
// PARAMETERS
//  NUM_PE     4  number of BCP engines served
//  HIST_DEPTH 8  pushed-literal history entries (only with BCP_ARB_DEDUP_EN)
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              synchronous, active-high reset (asserted = 1)
//  pe_imply_valid in  NUM_PE         per-PE implication strobe, no handshake
//  pe_imply_lit  in   NUM_PE x lit_t per-PE implied literal (signed, 0 reserved)
//  pe_conflict   in   NUM_PE         per-PE clause conflict strobe
//  pe_halt       out  NUM_PE         per-PE stall request
//  ucq_full      in   1              UCQ cannot accept a push this cycle
//  ucq_push      out  1              UCQ write enable
//  ucq_lit       out  lit_t          literal written to UCQ
//  conflict_clr  in   1              solver acknowledges conflict; return to run
//  conflict_out  out  1              sticky global conflict
//  busy          out  1              any capture slot occupied
// BEHAVIOUR
//  Reset: slots empty, rr_ptr=0, state=ARB_RUN, history empty; all outputs 0 (pe_halt all 0).
//  One capture slot (valid+lit) per PE.
//   - Slot i loads pe_imply_lit[i] when pe_imply_valid[i], state=ARB_RUN, and either slot empty or granted this cycle.
//   - pe_halt[i] = (slot_vld[i] & ~grant[i]) | (state==ARB_CONFLICT); combinational through ucq_full.
//  Grant: in ARB_RUN with ucq_full=0, pick first valid slot from rr_ptr upward, wrapping mod NUM_PE.
//   - One grant per cycle; rr_ptr <= (grant_idx+1) mod NUM_PE on a grant, else unchanged.
//  Push: combinational in the grant cycle. An implication strobed in cycle t is pushed no earlier than t+1.
//   - Granted lit==0 is dropped: slot cleared, no push.
//   - With ucq_full=1: no grant, slots hold, rr_ptr holds.
//  State ARB_RUN -> ARB_CONFLICT on any pe_conflict, or a negation hit (dedup only).
//   - Conflict beats a same-cycle grant: no push.
//  In ARB_CONFLICT: all slots and history cleared next edge; ucq_push=0; all pe_halt=1; conflict_out=1.
//   - ARB_CONFLICT -> ARB_RUN on conflict_clr. clr wins over same-cycle pe_conflict.
//   - Implications during ARB_CONFLICT are discarded.
//   - conflict_out is registered: 1 from the cycle after detection until the cycle after clr.
//  rst_n mid-operation discards all slots/history; pending implications are lost.
// CONFIGURATION
//  BCP_ARB_DEDUP_EN defined:
//   - HIST_DEPTH-entry shift register of pushed literals; entry written on each push, oldest evicted.
//   - Granted lit equal to any entry: dropped (slot cleared, no push).
//   - Granted lit equal to the negation of any entry: conflict, no push.
//  Undefined: no history; every nonzero granted lit is pushed; conflicts come only from pe_conflict.
// STRUCTURE
//  bcp_pkg: lit_t, LIT_W, arb_state_t {ARB_RUN, ARB_CONFLICT}, NUM_PE default.
//  Sub-module rr_arb: NUM_PE request vector + rr_ptr -> one-hot grant + index; purely combinational.
//  History CAM stays inline under `ifdef.
// TESTING
//  1. PE0=5, PE1=7 strobed cycle t, rr_ptr=0 -> push 5 @t+1, push 7 @t+2, rr_ptr=2.
//  2. Slot1=9, ucq_full=1 for 3 cycles -> no push, pe_halt[1]=1; push 9 in first cycle full=0.
//  3. DEDUP_EN: 5 pushed; PE2 implies 5 -> no push. PE3 implies -5 -> conflict_out=1 next cycle, all pe_halt=1.
//  4. pe_conflict[0] same cycle slot1 granted -> no push, ARB_CONFLICT. conflict_clr -> ARB_RUN, busy=0, history empty.
//  5. Four slots full, rst_n=1 one cycle -> all outputs 0, rr_ptr=0; next implication served by rr from PE0.
//  6. DEDUP_EN undefined: 5 then -5 -> both pushed, conflict_out=0. PE implies 0 -> no push.

Source files
------------

// File: rtl/bcp_pkg.sv
// Shared types for the BCP implication arbiter: literal type, arbiter state
// encoding, default sizing and literal negation helper.
package bcp_pkg;

  localparam int LIT_W          = 16;
  localparam int NUM_PE_DEF     = 4;
  localparam int HIST_DEPTH_DEF = 8;

  // Signed literal; the sign is the polarity, value 0 is reserved.
  typedef logic signed [LIT_W-1:0] lit_t;

  typedef enum logic [0:0] {
    ARB_RUN      = 1'b0,
    ARB_CONFLICT = 1'b1
  } arb_state_t;

  // Complement of a literal (opposite polarity of the same variable).
  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/bcp_imply_arb_rr_arb.sv
// Round-robin arbiter: picks the first request at or above rr_ptr_i,
// wrapping modulo NUM_PE. Purely combinational.
module rr_arb #(
  parameter int NUM_PE = 4,
  parameter int PTR_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic [NUM_PE-1:0] req_i,
  input  logic [PTR_W-1:0]  rr_ptr_i,
  output logic [NUM_PE-1:0] grant_o,
  output logic [PTR_W-1:0]  grant_idx_o,
  output logic              grant_vld_o
);

  // Scan from the pointer upward and take the first requester found.
  always_comb begin
    int sum;
    int idx;
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    sum         = 0;
    idx         = 0;
    for (int k = 0; k < NUM_PE; k++) begin
      sum = int'(rr_ptr_i) + k;
      idx = (sum >= NUM_PE) ? (sum - NUM_PE) : sum;
      if (!grant_vld_o && req_i[idx]) begin
        grant_vld_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = PTR_W'(idx);
      end else begin
        grant_vld_o = grant_vld_o;
      end
    end
  end

endmodule

// File: rtl/bcp_imply_arb.sv
// BCP implication arbiter: one capture slot per PE, round-robin
// serialisation into the UCQ, per-PE halt backpressure and a sticky global
// conflict held until the solver clears it.
// Optional feature: define BCP_ARB_DEDUP_EN to add a pushed-literal history
// that drops duplicate implications and flags complementary ones as conflicts.
module bcp_imply_arb
  import bcp_pkg::*;
#(
  parameter int NUM_PE     = NUM_PE_DEF
`ifdef BCP_ARB_DEDUP_EN
  ,
  parameter int HIST_DEPTH = HIST_DEPTH_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] pe_imply_valid,
  input  lit_t [NUM_PE-1:0] pe_imply_lit,
  input  logic [NUM_PE-1:0] pe_conflict,
  output logic [NUM_PE-1:0] pe_halt,
  input  logic              ucq_full,
  output logic              ucq_push,
  output lit_t              ucq_lit,
  input  logic              conflict_clr,
  output logic              conflict_out,
  output logic              busy
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  arb_state_t        state_q, state_d;
  logic [NUM_PE-1:0] slot_vld_q, slot_vld_d;
  lit_t [NUM_PE-1:0] slot_lit_q, slot_lit_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              conflict_out_q;

  logic [NUM_PE-1:0] req_s;
  logic [NUM_PE-1:0] grant_s;
  logic [PTR_W-1:0]  grant_idx_s;
  logic              grant_vld_s;
  lit_t              grant_lit_s;
  logic              dup_hit_s;
  logic              neg_hit_s;
  logic              conflict_det_s;
  logic              push_s;

  // Arbitration only runs while the UCQ can take a literal.
  assign req_s = ((state_q == ARB_RUN) && !ucq_full) ? slot_vld_q : '0;

  rr_arb #(
    .NUM_PE (NUM_PE),
    .PTR_W  (PTR_W)
  ) u_rr_arb (
    .req_i       (req_s),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .grant_vld_o (grant_vld_s)
  );

  assign grant_lit_s = slot_lit_q[grant_idx_s];

`ifdef BCP_ARB_DEDUP_EN
  lit_t [HIST_DEPTH-1:0] hist_lit_q;
  logic [HIST_DEPTH-1:0] hist_vld_q;

  // Match the granted literal (and its complement) against live history.
  always_comb begin
    dup_hit_s = 1'b0;
    neg_hit_s = 1'b0;
    for (int h = 0; h < HIST_DEPTH; h++) begin
      dup_hit_s = dup_hit_s | (hist_vld_q[h] && (hist_lit_q[h] == grant_lit_s));
      neg_hit_s = neg_hit_s | (hist_vld_q[h] && (hist_lit_q[h] == lit_neg(grant_lit_s)));
    end
    dup_hit_s = dup_hit_s & grant_vld_s;
    neg_hit_s = neg_hit_s & grant_vld_s;
  end

  // History shift register: newest push enters at index 0, oldest falls out.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      hist_lit_q <= '0;
      hist_vld_q <= '0;
    end else if ((state_q == ARB_CONFLICT) || conflict_det_s) begin
      hist_lit_q <= '0;
      hist_vld_q <= '0;
    end else if (push_s) begin
      hist_lit_q <= {hist_lit_q[HIST_DEPTH-2:0], grant_lit_s};
      hist_vld_q <= {hist_vld_q[HIST_DEPTH-2:0], 1'b1};
    end
  end
`else
  assign dup_hit_s = 1'b0;
  assign neg_hit_s = 1'b0;
`endif

  // A conflict (PE-reported or complementary literal) suppresses the push.
  assign conflict_det_s = (state_q == ARB_RUN) && ((|pe_conflict) || neg_hit_s);
  assign push_s         = grant_vld_s && (grant_lit_s != '0) && !dup_hit_s && !conflict_det_s;

  assign ucq_push     = push_s;
  assign ucq_lit      = push_s ? grant_lit_s : '0;
  assign pe_halt      = (slot_vld_q & ~grant_s) | {NUM_PE{state_q == ARB_CONFLICT}};
  assign busy         = |slot_vld_q;
  assign conflict_out = conflict_out_q;

  // Next-state: slot capture/release, pointer advance and conflict handling.
  always_comb begin
    state_d    = state_q;
    slot_vld_d = slot_vld_q;
    slot_lit_d = slot_lit_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_RUN: begin
        if (conflict_det_s) begin
          state_d    = ARB_CONFLICT;
          slot_vld_d = '0;
          slot_lit_d = '0;
        end else begin
          if (grant_vld_s) begin
            rr_ptr_d = (grant_idx_s == PTR_W'(NUM_PE - 1)) ? '0 : (grant_idx_s + PTR_W'(1));
          end else begin
            rr_ptr_d = rr_ptr_q;
          end
          for (int i = 0; i < NUM_PE; i++) begin
            if (pe_imply_valid[i] && (!slot_vld_q[i] || grant_s[i])) begin
              slot_vld_d[i] = 1'b1;
              slot_lit_d[i] = pe_imply_lit[i];
            end else if (grant_s[i]) begin
              slot_vld_d[i] = 1'b0;
              slot_lit_d[i] = '0;
            end else begin
              slot_vld_d[i] = slot_vld_q[i];
            end
          end
        end
      end
      ARB_CONFLICT: begin
        slot_vld_d = '0;
        slot_lit_d = '0;
        state_d    = conflict_clr ? ARB_RUN : ARB_CONFLICT;
      end
      default: begin
        state_d    = ARB_RUN;
        slot_vld_d = '0;
        slot_lit_d = '0;
      end
    endcase
  end

  // State, slot and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q        <= ARB_RUN;
      slot_vld_q     <= '0;
      slot_lit_q     <= '0;
      rr_ptr_q       <= '0;
      conflict_out_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_vld_q     <= slot_vld_d;
      slot_lit_q     <= slot_lit_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_out_q <= (state_d == ARB_CONFLICT);
    end
  end

endmodule

// File: tb/tb_bcp_imply_arb.sv
// Directed bench for bcp_imply_arb with a push scoreboard.
// Covers the BCP_ARB_DEDUP_EN build when that macro is defined.
module tb_bcp_imply_arb;
  import bcp_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] pe_imply_valid;
  lit_t [N-1:0] pe_imply_lit;
  logic [N-1:0] pe_conflict;
  logic [N-1:0] pe_halt;
  logic         ucq_full;
  logic         ucq_push;
  lit_t         ucq_lit;
  logic         conflict_clr;
  logic         conflict_out;
  logic         busy;

  int   tests = 0;
  int   fails = 0;
  lit_t sb[$];

  bcp_imply_arb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pe_imply_valid (pe_imply_valid),
    .pe_imply_lit   (pe_imply_lit),
    .pe_conflict    (pe_conflict),
    .pe_halt        (pe_halt),
    .ucq_full       (ucq_full),
    .ucq_push       (ucq_push),
    .ucq_lit        (ucq_lit),
    .conflict_clr   (conflict_clr),
    .conflict_out   (conflict_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Scoreboard: each UCQ push must match the oldest expected literal.
  always @(negedge clk) begin
    if (ucq_push === 1'b1) begin
      chk("push_expected", (sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("push_lit", ucq_lit, sb.pop_front());
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b1;
    pe_imply_valid = '0;
    pe_imply_lit   = '0;
    pe_conflict    = '0;
    ucq_full       = 1'b0;
    conflict_clr   = 1'b0;
    cyc();
    cyc();
    look();
    chk("rst_halt", pe_halt, 32'd0);
    chk("rst_push", ucq_push, 32'd0);
    chk("rst_conflict", conflict_out, 32'd0);
    chk("rst_busy", busy, 32'd0);
    cyc();
    rst_n = 1'b0;

    // Two strobes in one cycle: served PE0 then PE1, one per cycle.
    pe_imply_valid  = 4'b0011;
    pe_imply_lit[0] = 16'sd5;
    pe_imply_lit[1] = 16'sd7;
    sb.push_back(16'sd5);
    sb.push_back(16'sd7);
    look();
    chk("t1_no_push_same_cycle", ucq_push, 32'd0);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t1_push5", ucq_push, 32'd1);
    chk("t1_halt_pe1", pe_halt, 32'b0010);
    cyc();
    look();
    chk("t1_push7", ucq_push, 32'd1);
    chk("t1_halt_none", pe_halt, 32'd0);
    // rr_ptr is now 2: PE2 must be served before PE0.
    cyc();
    pe_imply_valid  = 4'b0101;
    pe_imply_lit[0] = 16'sd11;
    pe_imply_lit[2] = 16'sd13;
    sb.push_back(16'sd13);
    sb.push_back(16'sd11);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t1_rr_first", ucq_push, 32'd1);
    chk("t1_rr_halt_pe0", pe_halt, 32'b0001);
    cyc();
    look();
    chk("t1_rr_second", ucq_push, 32'd1);
    cyc();
    look();
    chk("t1_idle_busy", busy, 32'd0);

    // UCQ full holds the slot and halts its PE.
    cyc();
    pe_imply_valid  = 4'b0010;
    pe_imply_lit[1] = 16'sd9;
    ucq_full        = 1'b1;
    sb.push_back(16'sd9);
    for (int k = 0; k < 3; k++) begin
      cyc();
      pe_imply_valid = '0;
      look();
      chk("t2_full_no_push", ucq_push, 32'd0);
      chk("t2_full_halt", pe_halt, 32'b0010);
      chk("t2_full_busy", busy, 32'd1);
    end
    cyc();
    ucq_full = 1'b0;
    look();
    chk("t2_push_after_full", ucq_push, 32'd1);
    chk("t2_halt_released", pe_halt, 32'd0);
    cyc();
    look();
    chk("t2_busy_clear", busy, 32'd0);

`ifdef BCP_ARB_DEDUP_EN
    // Duplicate literal dropped; complementary literal raises conflict.
    pe_imply_valid  = 4'b0001;
    pe_imply_lit[0] = 16'sd5;
    sb.push_back(16'sd5);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t3_push5", ucq_push, 32'd1);
    cyc();
    pe_imply_valid  = 4'b0100;
    pe_imply_lit[2] = 16'sd5;
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t3_dup_no_push", ucq_push, 32'd0);
    chk("t3_dup_busy", busy, 32'd1);
    cyc();
    pe_imply_valid  = 4'b1000;
    pe_imply_lit[3] = -16'sd5;
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t3_neg_no_push", ucq_push, 32'd0);
    chk("t3_neg_conf_not_yet", conflict_out, 32'd0);
    cyc();
    look();
    chk("t3_conflict_out", conflict_out, 32'd1);
    chk("t3_halt_all", pe_halt, 32'b1111);
    conflict_clr = 1'b1;
    cyc();
    conflict_clr = 1'b0;
    look();
    chk("t3_clr_conflict", conflict_out, 32'd0);
    chk("t3_clr_halt", pe_halt, 32'd0);
    cyc();
`else
    // Without history, complementary literals both reach the UCQ.
    pe_imply_valid  = 4'b0001;
    pe_imply_lit[0] = 16'sd5;
    sb.push_back(16'sd5);
    cyc();
    pe_imply_lit[0] = -16'sd5;
    sb.push_back(-16'sd5);
    look();
    chk("t6_push5", ucq_push, 32'd1);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t6_push_neg5", ucq_push, 32'd1);
    chk("t6_no_conflict", conflict_out, 32'd0);
    cyc();
    pe_imply_valid  = 4'b0010;
    pe_imply_lit[1] = 16'sd0;
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t6_zero_no_push", ucq_push, 32'd0);
    chk("t6_zero_busy", busy, 32'd1);
    cyc();
    look();
    chk("t6_zero_cleared", busy, 32'd0);
    chk("t6_still_no_conflict", conflict_out, 32'd0);
    cyc();
`endif

    // PE conflict beats a same-cycle grant; clr beats same-cycle conflict.
    pe_imply_valid  = 4'b0010;
    pe_imply_lit[1] = 16'sd17;
    cyc();
    pe_imply_valid = '0;
    pe_conflict    = 4'b0001;
    look();
    chk("t4_conflict_no_push", ucq_push, 32'd0);
    cyc();
    pe_conflict     = '0;
    pe_imply_valid  = 4'b0100;
    pe_imply_lit[2] = 16'sd21;
    look();
    chk("t4_conflict_out", conflict_out, 32'd1);
    chk("t4_halt_all", pe_halt, 32'b1111);
    chk("t4_in_conflict_no_push", ucq_push, 32'd0);
    cyc();
    pe_imply_valid = '0;
    conflict_clr   = 1'b1;
    pe_conflict    = 4'b0001;
    look();
    chk("t4_still_conflict", conflict_out, 32'd1);
    cyc();
    conflict_clr = 1'b0;
    pe_conflict  = '0;
    look();
    chk("t4_clr_conflict_out", conflict_out, 32'd0);
    chk("t4_clr_busy", busy, 32'd0);
    chk("t4_clr_halt", pe_halt, 32'd0);
    // History emptied: a literal seen before the conflict is pushed again.
    pe_imply_valid  = 4'b0001;
    pe_imply_lit[0] = 16'sd5;
    sb.push_back(16'sd5);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t4_hist_empty_push", ucq_push, 32'd1);

    // Reset with all slots full; afterwards rr restarts at PE0.
    cyc();
    pe_imply_valid  = 4'b1111;
    pe_imply_lit[0] = 16'sd1;
    pe_imply_lit[1] = 16'sd2;
    pe_imply_lit[2] = 16'sd3;
    pe_imply_lit[3] = 16'sd4;
    ucq_full        = 1'b1;
    cyc();
    pe_imply_valid = '0;
    rst_n          = 1'b1;
    look();
    chk("t5_full_busy", busy, 32'd1);
    chk("t5_full_halt", pe_halt, 32'b1111);
    cyc();
    rst_n    = 1'b0;
    ucq_full = 1'b0;
    look();
    chk("t5_rst_busy", busy, 32'd0);
    chk("t5_rst_halt", pe_halt, 32'd0);
    chk("t5_rst_push", ucq_push, 32'd0);
    chk("t5_rst_conflict", conflict_out, 32'd0);
    pe_imply_valid  = 4'b0011;
    pe_imply_lit[0] = 16'sd31;
    pe_imply_lit[1] = 16'sd32;
    sb.push_back(16'sd31);
    sb.push_back(16'sd32);
    cyc();
    pe_imply_valid = '0;
    look();
    chk("t5_rr_pe0_first", ucq_push, 32'd1);
    cyc();
    look();
    chk("t5_rr_pe1_second", ucq_push, 32'd1);

    cyc();
    cyc();
    cyc();
    look();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
